// File: rtl/stride_pkg.sv
// Shared types and elaboration helpers for the stride sequencer: FSM state,
// phase-width function and the word/stride legality check.
package stride_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    function automatic int phase_width(input int stride);
        return (stride > 1) ? $clog2(stride) : 1;
    endfunction

    function automatic bit len_stride_legal(input int len, input int stride);
        return (stride >= 1) && (len >= stride) && ((len % stride) == 0);
    endfunction

    localparam int DEFAULT_LEN    = 8;
    localparam int DEFAULT_STRIDE = 2;
    localparam bit DEFAULT_CFG_LEGAL = len_stride_legal(DEFAULT_LEN, DEFAULT_STRIDE);

endpackage

// File: rtl/stride_sequencer_if.sv
// Word-in / slice-out handshake bundle of the stride sequencer; master is the
// sequencer side, slave is the loader/consumer side.
interface stride_sequencer_if
    import stride_pkg::*;
#(
    parameter int LEN    = DEFAULT_LEN,
    parameter int STRIDE = DEFAULT_STRIDE
);
    localparam int PW = phase_width(STRIDE);

    logic                  in_valid;
    logic                  in_ready;
    logic [LEN-1:0]        in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [LEN/STRIDE-1:0] out_data;
    logic [PW-1:0]         out_phase;
    logic                  out_last;
    logic                  out_parity;

    modport master (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_phase, out_last, out_parity
    );

    modport slave (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_phase, out_last, out_parity
    );

endinterface

// File: rtl/stride_phase_sel.sv
// Combinational phase-offset stride selector: slice[i] = word[i*STRIDE + phase].
module stride_phase_sel
    import stride_pkg::*;
#(
    parameter int LEN    = DEFAULT_LEN,
    parameter int STRIDE = DEFAULT_STRIDE,
    parameter int PW     = phase_width(STRIDE)
) (
    input  logic [LEN-1:0]        word,
    input  logic [PW-1:0]         phase,
    output logic [LEN/STRIDE-1:0] slice
);
    localparam int NS = LEN / STRIDE;

    // Row i of the grid holds bits i*STRIDE .. i*STRIDE+STRIDE-1; phase picks the column.
    logic [NS-1:0][STRIDE-1:0] grid;

    assign grid = word;

    always_comb begin
        slice = '0;
        for (int i = 0; i < NS; i++) begin
            slice[i] = grid[i][phase];
        end
    end

endmodule

// File: rtl/stride_sequencer.sv
// Captures one LEN-bit word per handshake and streams its STRIDE phase slices.
// Optional even parity on out_data when STRIDE_SEQ_PARITY_EN is defined.
module stride_sequencer
    import stride_pkg::*;
#(
    parameter int LEN    = DEFAULT_LEN,
    parameter int STRIDE = DEFAULT_STRIDE
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    stride_sequencer_if.master        bus,
    output logic                      busy
);
    localparam int PW         = phase_width(STRIDE);
    localparam bit CFG_LEGAL  = len_stride_legal(LEN, STRIDE);
    localparam logic [PW-1:0] LAST_PHASE = PW'(STRIDE - 1);

    if (!CFG_LEGAL) begin : g_cfg_check
        $error("stride_sequencer: LEN must be a nonzero multiple of STRIDE");
    end

    state_e         state_q, state_d;
    logic [PW-1:0]  phase_q, phase_d;
    logic [LEN-1:0] word_q,  word_d;

    logic in_fire;
    logic out_fire;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            word_q  <= word_d;
        end
    end

    // NOTE: every signal gets a default before any branch, otherwise an
    // unassigned path would infer a latch.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        word_d  = word_q;
        if (flush) begin
            state_d = ST_IDLE;
            phase_d = '0;
        end else begin
            if (out_fire) begin
                if (bus.out_last) begin
                    state_d = ST_IDLE;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            // A new word wins over the finishing word's return to IDLE.
            if (in_fire) begin
                state_d = ST_SEND;
                phase_d = '0;
                word_d  = bus.in_data;
            end
        end
    end

    always_comb begin
        busy          = (state_q == ST_SEND);
        bus.out_valid = (state_q == ST_SEND);
        bus.out_phase = phase_q;
        bus.out_last  = !rst && (phase_q == LAST_PHASE);
        bus.in_ready  = 1'b0;
        if (!rst && !flush) begin
            unique case (state_q)
                ST_IDLE: bus.in_ready = 1'b1;
                ST_SEND: bus.in_ready = bus.out_last && bus.out_ready;
                default: bus.in_ready = 1'b0;
            endcase
        end
        in_fire  = bus.in_valid && bus.in_ready;
        out_fire = bus.out_valid && bus.out_ready;
    end

    stride_phase_sel #(
        .LEN    (LEN),
        .STRIDE (STRIDE),
        .PW     (PW)
    ) u_phase_sel (
        .word  (word_q),
        .phase (phase_q),
        .slice (bus.out_data)
    );

`ifdef STRIDE_SEQ_PARITY_EN
    assign bus.out_parity = ^bus.out_data;
`else
    assign bus.out_parity = 1'b0;
`endif

endmodule

// File: tb/tb_stride_sequencer.sv
// Self-checking bench for stride_sequencer: transaction-level reference model
// compared every cycle, directed scenarios with literal expectations, random traffic.
module tb_stride_sequencer;
    localparam int LEN    = 8;
    localparam int STRIDE = 2;
    localparam int NS     = LEN / STRIDE;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic busy;

    stride_sequencer_if #(.LEN(LEN), .STRIDE(STRIDE)) bus ();

    stride_sequencer #(.LEN(LEN), .STRIDE(STRIDE)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Bit i of the phase-p slice is word bit i*STRIDE + p.
    function automatic int slice_of(input int word, input int p);
        int r = 0;
        for (int i = 0; i < NS; i++) r |= ((word >> (i * STRIDE + p)) & 1) << i;
        return r;
    endfunction

    function automatic int parity_of(input int v);
`ifdef STRIDE_SEQ_PARITY_EN
        return $countones(v) & 1;
`else
        return v & 0;
`endif
    endfunction

    // Reference model: the held word, which beat of it is on the output, and whether one is held.
    int m_word  = 0;
    int m_beat  = 0;
    bit m_busy  = 1'b0;

    always @(negedge clk) begin
        int  exp_data;
        bit  exp_last;
        bit  exp_ready;
        if (rst) begin
            check("rst_outputs",
                  {bus.out_valid, bus.in_ready, bus.out_last, bus.out_parity, busy,
                   32'(bus.out_phase), 32'(bus.out_data)} != 0, 0);
            m_word = 0;
            m_beat = 0;
            m_busy = 1'b0;
        end else begin
            exp_data  = slice_of(m_word, m_beat);
            exp_last  = (m_beat == STRIDE - 1);
            exp_ready = !flush && (!m_busy || (exp_last && bus.out_ready));
            check("m_out_valid",  bus.out_valid,  m_busy);
            check("m_busy",       busy,           m_busy);
            check("m_out_data",   bus.out_data,   exp_data);
            check("m_out_phase",  bus.out_phase,  m_beat);
            check("m_out_last",   bus.out_last,   exp_last);
            check("m_in_ready",   bus.in_ready,   exp_ready);
            check("m_out_parity", bus.out_parity, parity_of(exp_data));
            if (flush) begin
                m_busy = 1'b0;
                m_beat = 0;
            end else begin
                if (m_busy && bus.out_ready) begin
                    if (exp_last) begin
                        m_busy = 1'b0;
                        m_beat = 0;
                    end else begin
                        m_beat++;
                    end
                end
                if (bus.in_valid && exp_ready) begin
                    m_word = int'(bus.in_data);
                    m_beat = 0;
                    m_busy = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        flush         = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        #1;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("post_rst_in_ready", bus.in_ready, 1);
        check("post_rst_out_valid", bus.out_valid, 0);
        check("post_rst_busy", busy, 0);
        check("pin_model_slice", slice_of(8'hA0, 1), 4'b1100);

        // Single word 1010_0000
        bus.in_valid = 1'b1;
        bus.in_data  = 8'b1010_0000;
        tick();
        bus.in_valid = 1'b0;
        #1;
        check("single_p0_data", bus.out_data, 4'b0000);
        check("single_p0_phase", bus.out_phase, 0);
        check("single_p0_last", bus.out_last, 0);
        tick();
        check("single_p1_data", bus.out_data, 4'b1100);
        check("single_p1_last", bus.out_last, 1);
        check("single_p1_parity", bus.out_parity, 0);
        tick();
        check("single_done_busy", busy, 0);
        check("single_done_valid", bus.out_valid, 0);

        // Back-to-back 0101_0101 then 1010_1010
        bus.in_valid = 1'b1;
        bus.in_data  = 8'b0101_0101;
        tick();
        bus.in_data = 8'b1010_1010;
        #1;
        check("b2b_0_data", bus.out_data, 4'b1111);
        check("b2b_0_in_ready", bus.in_ready, 0);
        tick();
        check("b2b_1_data", bus.out_data, 4'b0000);
        check("b2b_1_in_ready", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        #1;
        check("b2b_2_data", bus.out_data, 4'b0000);
        check("b2b_2_phase", bus.out_phase, 0);
        check("b2b_2_valid", bus.out_valid, 1);
        tick();
        check("b2b_3_data", bus.out_data, 4'b1111);
        check("b2b_3_last", bus.out_last, 1);
        tick();
        check("b2b_done", busy, 0);

        // Backpressure on phase 0 of 0101_0101
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'b0101_0101;
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_hold_data", bus.out_data, 4'b1111);
            check("bp_hold_phase", bus.out_phase, 0);
            if (k < 2) tick();
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_data", bus.out_data, 4'b1111);
        tick();
        check("bp_p1_data", bus.out_data, 4'b0000);
        check("bp_p1_phase", bus.out_phase, 1);
        tick();

        // Flush during phase 1
        bus.in_valid = 1'b1;
        bus.in_data  = 8'b0101_0101;
        tick();
        bus.in_data = 8'b1010_1010;
        tick();
        check("flush_pre_phase", bus.out_phase, 1);
        flush = 1'b1;
        #1;
        check("flush_in_ready", bus.in_ready, 0);
        tick();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("flush_idle_valid", bus.out_valid, 0);
        check("flush_idle_busy", busy, 0);
        tick();

        // Asynchronous reset mid-word
        bus.in_valid = 1'b1;
        bus.in_data  = 8'b1100_0011;
        tick();
        bus.in_valid = 1'b0;
        check("rstmid_valid_before", bus.out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("rstmid_valid", bus.out_valid, 0);
        check("rstmid_in_ready", bus.in_ready, 0);
        check("rstmid_data", bus.out_data, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Random traffic, checked by the model every cycle
        for (int n = 0; n < 600; n++) begin
            bus.in_valid  = ($urandom_range(0, 9) < 6);
            bus.in_data   = LEN'($urandom);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            flush         = ($urandom_range(0, 19) == 0);
            tick();
        end
        idle_inputs();
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stride_sequencer.md
# stride_sequencer

Sequencer that streams wide configuration words through the stride datapath. It captures one LEN-bit word per valid/ready handshake, then emits STRIDE phase slices of LEN/STRIDE bits each, one per handshake beat. Phase p gathers bits p, p+STRIDE, p+2·STRIDE, …. It sits between the word source (config loader) and the narrow PAL array programming port, and owns the phase counter and backpressure.

## Interface
- LEN, 8, input word width; LEN % STRIDE == 0 is required.
- STRIDE, 2, number of phases per word; STRIDE ≥ 1.
- PW (localparam), max(1, $clog2(STRIDE)), phase index width.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous abort of the current word.
- in_valid  in  1  input word valid.
- in_ready  out  1  sequencer can accept a word.
- in_data  in  LEN  input word.
- out_valid  out  1  slice valid.
- out_ready  in  1  consumer accepts slice.
- out_data  out  LEN/STRIDE  slice; out_data[i] = word[i·STRIDE + phase].
- out_phase  out  PW  current phase index.
- out_last  out  1  current slice is phase STRIDE-1.
- out_parity  out  1  even parity of out_data (see Configuration).
- busy  out  1  a word is held (state SEND).

## Operation
- States: IDLE and SEND. The reset state is IDLE with phase = 0, word register = 0, and out_valid = 0.
- In IDLE, in_ready = 1. On in_valid && in_ready, latch in_data, set phase = 0, and go to SEND.
- In SEND, out_valid = 1. On out_valid && out_ready, advance the phase.
  - If phase < STRIDE-1, increment the phase.
  - If phase == STRIDE-1 (out_last), the word is finished.
- Chaining: in SEND, in_ready = out_last && out_ready. A word finished in the same cycle as a new input handshake loads the new word, resets phase to 0, and stays in SEND. Otherwise a finished word returns to IDLE.
- flush has priority over every handshake. When flush is high:
  - return to IDLE and set phase = 0;
  - in_ready = 0 that cycle, so no input is accepted;
  - any out handshake that cycle is ignored.
- The slice is selected combinationally from the held word register and phase. Outputs are stable while out_valid && !out_ready.
- STRIDE = 1: out_phase is always 0, out_last is always 1, and out_data equals the word.
- While rst is high, all outputs are 0, including in_ready.

## Timing
- A word handshaked at edge k gives phase 0 valid after edge k. Latency is 1 cycle.
- Sustained throughput is one word per STRIDE cycles, with no bubble between words when chaining.
- Backpressure: out_ready low holds the phase and out_data unchanged indefinitely.
- Asserting rst mid-word asynchronously clears state to IDLE. The partial word is discarded and no further slices are emitted.
- out_last, out_phase, and out_data change only on clock edges, or asynchronously on rst.

## Configuration
- STRIDE_SEQ_PARITY_EN defined: out_parity = ^out_data. It is combinational and valid whenever out_valid is high.
- STRIDE_SEQ_PARITY_EN undefined: out_parity is tied to 0 and no parity logic is synthesized. The port is always present.

## Structure
- Shared package stride_pkg holds:
  - the state enum (ST_IDLE, ST_SEND);
  - a function for the phase width;
  - the LEN % STRIDE legality check constant, used in an elaboration-time assertion.
- One sub-module: stride_phase_sel. It is combinational, taking the word and phase and producing the slice. It is the phase-offset generalisation of the existing stride selector.
- The FSM, phase counter, and word register live in stride_sequencer.

## Test plan
All scenarios use LEN=8, STRIDE=2 unless stated.
- Reset: after rst, out_valid=0, busy=0, and in_ready=1 once rst is released.
- Single word: 8'b1010_0000 with out_ready=1 gives phase0 4'b0000, then phase1 4'b1100 with out_last=1. busy drops on the following cycle.
- Back-to-back: 8'b0101_0101 then 8'b1010_1010 with in_valid held gives 1111, 0000, 0000, 1111 on consecutive cycles. in_ready pulses only on the last beats.
- Backpressure: out_ready low for 3 cycles during phase0 of 8'b0101_0101 holds out_data=1111 and out_phase=0 unchanged. Release gives 1111 accepted, then 0000.
- Flush and reset mid-word:
  - flush during phase1 gives IDLE next cycle, with no phase1 handshake counted and in_ready=0 in the flush cycle;
  - rst asserted mid-edge clears out_valid immediately.
- Parity, with STRIDE_SEQ_PARITY_EN defined: slice 4'b1100 gives out_parity=0; LEN=6/STRIDE=2 word 6'b000001 gives phase0 3'b001 with out_parity=1. Without the macro, out_parity=0 always.
